// File: rtl/mfp_ahb_const_pkg.sv
// mfp_ahb_const: shared AHB-Lite constants for the MFP bus arbiter.
//   HTRANS_*      - transfer-type encodings
//   MASTER_IDX_W  - width of a master index (two masters)
//   bus_unlocked  - true when the owner's current beat allows re-arbitration
package mfp_ahb_const;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int MASTER_IDX_W = 1;

  typedef logic [MASTER_IDX_W-1:0] master_idx_t;

  // SEQ/BUSY continue a burst and HMASTLOCK pins a locked sequence, so only
  // an unlocked IDLE or NONSEQ beat lets another master take the bus.
  function automatic logic bus_unlocked(input logic [1:0] htrans, input logic lock);
    return !lock && ((htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ));
  endfunction

endpackage

// File: rtl/mfp_arb_pick.sv
// mfp_arb_pick: 2-way grant pick with a registered last-grant record.
//   clk, rst  - bus clock, synchronous active-high reset
//   decide    - an arbitration decision is taken this cycle
//   req0/req1 - NONSEQ requests from master 0 / master 1
//   gnt       - picked master index (valid when any_req)
//   any_req   - at least one master is requesting
// Optional feature: define MFP_ARB_RR_EN for round-robin; otherwise fixed
// priority with master 0 always ahead of master 1.
module mfp_arb_pick
  import mfp_ahb_const::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        decide,
  input  logic        req0,
  input  logic        req1,
  output master_idx_t gnt,
  output logic        any_req
);

  // Master that won the last decision; it loses the next tie. Held at 1 in
  // the fixed-priority build, which makes master 0 win every tie.
  master_idx_t last_grant;

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1)
      gnt = ~last_grant;
    else if (req1)
      gnt = 1'b1;
    else
      gnt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (decide && any_req)
`ifdef MFP_ARB_RR_EN
      last_grant <= gnt;
`else
      last_grant <= 1'b1;
`endif
  end

endmodule

// File: rtl/mfp_ahb_arbiter.sv
// mfp_ahb_arbiter: two-master AHB-Lite arbiter (M0 = m14k core, M1 = loader/DMA).
//   HCLK, SI_Reset            - bus clock, synchronous active-high reset
//   Mx_H* inputs (x=0,1)      - master address/control/write data
//   Mx_HRDATA/HREADY/HRESP    - per-master returns
//   S_H* outputs              - muxed bus towards the slave fabric
//   S_HRDATA/HREADY/HRESP     - slave fabric returns
//   ARB_Owner                 - registered address-phase owner
// Optional feature: MFP_ARB_RR_EN selects round-robin instead of fixed priority.
module mfp_ahb_arbiter
  import mfp_ahb_const::*;
#(
  parameter int DATA_W = 32
)
(
  input  logic              HCLK,
  input  logic              SI_Reset,
  input  logic [31:0]       M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M0_HBURST,
  input  logic [3:0]        M0_HPROT,
  input  logic              M0_HMASTLOCK,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic [DATA_W-1:0] M0_HRDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  input  logic [31:0]       M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [2:0]        M1_HBURST,
  input  logic [3:0]        M1_HPROT,
  input  logic              M1_HMASTLOCK,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic [31:0]       S_HADDR,
  output logic [1:0]        S_HTRANS,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [2:0]        S_HBURST,
  output logic [3:0]        S_HPROT,
  output logic              S_HMASTLOCK,
  output logic [DATA_W-1:0] S_HWDATA,
  input  logic [DATA_W-1:0] S_HRDATA,
  input  logic              S_HREADY,
  input  logic              S_HRESP,
  output logic              ARB_Owner
);

  master_idx_t aowner;
  master_idx_t downer;
  logic        dvalid;

  logic        req0;
  logic        req1;
  logic [1:0]  own_trans;
  logic        own_lock;
  logic        arb_en;
  master_idx_t gnt;
  logic        any_req;
  master_idx_t winner;
  logic [1:0]  win_trans;

  // Address phase: decide the winner from the owner's lock state
  assign req0      = (M0_HTRANS == HTRANS_NONSEQ);
  assign req1      = (M1_HTRANS == HTRANS_NONSEQ);
  assign own_trans = aowner ? M1_HTRANS    : M0_HTRANS;
  assign own_lock  = aowner ? M1_HMASTLOCK : M0_HMASTLOCK;
  assign arb_en    = S_HREADY && bus_unlocked(own_trans, own_lock);

  mfp_arb_pick u_pick (
    .clk     (HCLK),
    .rst     (SI_Reset),
    .decide  (arb_en),
    .req0    (req0),
    .req1    (req1),
    .gnt     (gnt),
    .any_req (any_req)
  );

  // Without a requester the current owner stays parked and its IDLE passes out.
  assign winner    = (arb_en && any_req) ? gnt : aowner;
  assign win_trans = winner ? M1_HTRANS : M0_HTRANS;

  always_comb begin
    if (winner) begin
      S_HADDR     = M1_HADDR;
      S_HWRITE    = M1_HWRITE;
      S_HSIZE     = M1_HSIZE;
      S_HBURST    = M1_HBURST;
      S_HPROT     = M1_HPROT;
      S_HMASTLOCK = M1_HMASTLOCK;
    end else begin
      S_HADDR     = M0_HADDR;
      S_HWRITE    = M0_HWRITE;
      S_HSIZE     = M0_HSIZE;
      S_HBURST    = M0_HBURST;
      S_HPROT     = M0_HPROT;
      S_HMASTLOCK = M0_HMASTLOCK;
    end
  end
  assign S_HTRANS = win_trans;

  // Data phase: ownership moves only when the slave accepts the beat
  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      aowner <= 1'b0;
      downer <= 1'b0;
      dvalid <= 1'b0;
    end else if (S_HREADY) begin
      aowner <= winner;
      downer <= winner;
      dvalid <= win_trans[1];
    end
  end

  assign S_HWDATA  = !dvalid ? '0 : (downer ? M1_HWDATA : M0_HWDATA);
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HRESP  = dvalid && !downer && S_HRESP;
  assign M1_HRESP  = dvalid &&  downer && S_HRESP;

  // A master tied to the bus (address winner or data owner) follows the slave;
  // one with a pending transfer that is not on the bus is stalled; an idle
  // bystander sees ready so it can start whenever it likes.
  always_comb begin
    if (!winner || (dvalid && !downer))
      M0_HREADY = S_HREADY;
    else
      M0_HREADY = ~M0_HTRANS[1];
    if (winner || (dvalid && downer))
      M1_HREADY = S_HREADY;
    else
      M1_HREADY = ~M1_HTRANS[1];
  end

  assign ARB_Owner = aowner;

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// tb_mfp_ahb_arbiter: directed self-checking bench for mfp_ahb_arbiter.
// Inputs change 1 ns after each rising edge; outputs are checked 2 ns later.
module tb_mfp_ahb_arbiter;

  logic        HCLK = 1'b0;
  logic        SI_Reset;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [2:0]  M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic        M0_HMASTLOCK, M1_HMASTLOCK;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        M0_HREADY, M1_HREADY;
  logic        M0_HRESP, M1_HRESP;
  logic [31:0] S_HADDR;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE;
  logic [2:0]  S_HSIZE;
  logic [2:0]  S_HBURST;
  logic [3:0]  S_HPROT;
  logic        S_HMASTLOCK;
  logic [31:0] S_HWDATA;
  logic [31:0] S_HRDATA;
  logic        S_HREADY;
  logic        S_HRESP;
  logic        ARB_Owner;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_arbiter dut (
    .HCLK(HCLK), .SI_Reset(SI_Reset),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT),
    .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
    .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT),
    .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
    .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HPROT(S_HPROT),
    .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA),
    .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY), .S_HRESP(S_HRESP),
    .ARB_Owner(ARB_Owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_all();
    M0_HTRANS = 2'b00; M0_HADDR = '0; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2;
    M0_HBURST = 3'd0;  M0_HPROT = 4'h3; M0_HMASTLOCK = 1'b0;
    M1_HTRANS = 2'b00; M1_HADDR = '0; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2;
    M1_HBURST = 3'd0;  M1_HPROT = 4'h3; M1_HMASTLOCK = 1'b0;
  endtask

  task automatic do_reset();
    SI_Reset = 1'b1;
    idle_all();
    tick();
    SI_Reset = 1'b0;
  endtask

  logic [31:0] exp_addr [4];

  initial begin
    idle_all();
    SI_Reset  = 1'b1;
    M0_HWDATA = 32'hDEAD_0000;
    M1_HWDATA = 32'hDEAD_0001;
    S_HRDATA  = '0;
    S_HREADY  = 1'b1;
    S_HRESP   = 1'b0;

    // Reset state
    tick(); tick();
    settle();
    chk("rst_owner",   ARB_Owner, 1'b0);
    chk("rst_htrans",  S_HTRANS,  2'b00);
    chk("rst_hwdata",  S_HWDATA,  32'h0);
    chk("rst_m0resp",  M0_HRESP,  1'b0);
    chk("rst_m1resp",  M1_HRESP,  1'b0);
    chk("rst_m0rdy",   M0_HREADY, 1'b1);
    chk("rst_m1rdy",   M1_HREADY, 1'b1);
    SI_Reset = 1'b0;

    // Single M0 read, zero-wait grant
    M0_HTRANS = 2'b10; M0_HADDR = 32'h0000_0100;
    settle();
    chk("rd_haddr",  S_HADDR,   32'h100);
    chk("rd_htrans", S_HTRANS,  2'b10);
    chk("rd_m0rdy",  M0_HREADY, 1'b1);
    tick();
    M0_HTRANS = 2'b00;
    S_HRDATA  = 32'hCAFE_0001;
    settle();
    chk("rd_m0rdata", M0_HRDATA, 32'hCAFE_0001);
    chk("rd_m1rdata", M1_HRDATA, 32'hCAFE_0001);
    chk("rd_owner",   ARB_Owner, 1'b0);
    chk("rd_idle",    S_HTRANS,  2'b00);
    tick();

    // Simultaneous requests with the bus free: M0 first, then M1
    do_reset();
    M0_HTRANS = 2'b10; M0_HADDR = 32'h10;
    M1_HTRANS = 2'b10; M1_HADDR = 32'h20;
    settle();
    chk("dual_haddr0", S_HADDR,   32'h10);
    chk("dual_m0rdy",  M0_HREADY, 1'b1);
    chk("dual_m1rdy",  M1_HREADY, 1'b0);
    tick();
    M0_HTRANS = 2'b00;
    settle();
    chk("dual_haddr1", S_HADDR,   32'h20);
    chk("dual_m1rdy2", M1_HREADY, 1'b1);
    tick();
    M1_HTRANS = 2'b00;
    settle();
    chk("dual_owner1", ARB_Owner, 1'b1);
    tick();

    // Continuous contention for four decisions
    do_reset();
`ifdef MFP_ARB_RR_EN
    exp_addr[0] = 32'h10; exp_addr[1] = 32'h20; exp_addr[2] = 32'h10; exp_addr[3] = 32'h20;
`else
    exp_addr[0] = 32'h10; exp_addr[1] = 32'h10; exp_addr[2] = 32'h10; exp_addr[3] = 32'h10;
`endif
    M0_HTRANS = 2'b10; M0_HADDR = 32'h10;
    M1_HTRANS = 2'b10; M1_HADDR = 32'h20;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("contend_%0d", i), S_HADDR, exp_addr[i]);
      tick();
    end
    idle_all();
    tick();

    // M1 WRAP4 burst is not split by an M0 request from beat 2
    do_reset();
    M1_HTRANS = 2'b10; M1_HADDR = 32'h40; M1_HBURST = 3'b010; M1_HWRITE = 1'b1;
    settle();
    chk("burst_b1_addr", S_HADDR,   32'h40);
    chk("burst_b1_rdy",  M1_HREADY, 1'b1);
    tick();
    M1_HTRANS = 2'b11; M1_HADDR = 32'h44;
    M0_HTRANS = 2'b10; M0_HADDR = 32'h80;
    settle();
    chk("burst_b2_addr",  S_HADDR,   32'h44);
    chk("burst_b2_hburst", S_HBURST, 3'b010);
    chk("burst_b2_m0rdy", M0_HREADY, 1'b0);
    tick();
    M1_HADDR = 32'h48;
    settle();
    chk("burst_b3_addr",  S_HADDR,   32'h48);
    chk("burst_b3_m0rdy", M0_HREADY, 1'b0);
    tick();
    M1_HADDR = 32'h4C;
    settle();
    chk("burst_b4_addr",  S_HADDR,   32'h4C);
    chk("burst_b4_m0rdy", M0_HREADY, 1'b0);
    tick();
    M1_HTRANS = 2'b00; M1_HWDATA = 32'h1111_0004;
    settle();
    chk("burst_m0_addr",   S_HADDR,   32'h80);
    chk("burst_m0_rdy",    M0_HREADY, 1'b1);
    chk("burst_last_wdat", S_HWDATA,  32'h1111_0004);
    tick();
    M0_HTRANS = 2'b00;
    settle();
    chk("burst_owner0", ARB_Owner, 1'b0);
    tick();

    // Two slave wait states in an M0 write data phase while M1 waits
    M0_HTRANS = 2'b10; M0_HADDR = 32'h200; M0_HWRITE = 1'b1;
    settle();
    chk("ws_addr",   S_HADDR,  32'h200);
    chk("ws_hwrite", S_HWRITE, 1'b1);
    tick();
    M0_HTRANS = 2'b00; M0_HWDATA = 32'hA5A5_0200;
    M1_HTRANS = 2'b10; M1_HADDR = 32'h300; M1_HWRITE = 1'b0; M1_HBURST = 3'd0;
    S_HREADY  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("ws%0d_wdata", i), S_HWDATA,  32'hA5A5_0200);
      chk($sformatf("ws%0d_m0rdy", i), M0_HREADY, 1'b0);
      chk($sformatf("ws%0d_m1rdy", i), M1_HREADY, 1'b0);
      tick();
    end
    S_HREADY = 1'b1;
    settle();
    chk("ws_end_wdata", S_HWDATA,  32'hA5A5_0200);
    chk("ws_end_m0rdy", M0_HREADY, 1'b1);
    chk("ws_end_m1rdy", M1_HREADY, 1'b1);
    chk("ws_end_addr",  S_HADDR,   32'h300);
    tick();

    // Two-cycle ERROR on M1's read goes to M1 only
    M1_HTRANS = 2'b00;
    S_HRESP = 1'b1; S_HREADY = 1'b0;
    settle();
    chk("err1_m1resp", M1_HRESP,  1'b1);
    chk("err1_m0resp", M0_HRESP,  1'b0);
    chk("err1_owner",  ARB_Owner, 1'b1);
    tick();
    S_HREADY = 1'b1;
    settle();
    chk("err2_m1resp", M1_HRESP, 1'b1);
    chk("err2_m0resp", M0_HRESP, 1'b0);
    tick();
    S_HRESP = 1'b0;
    settle();
    chk("err_owner_kept", ARB_Owner, 1'b1);

    // Reset in the middle of an M1 burst
    M1_HTRANS = 2'b10; M1_HADDR = 32'h400; M1_HWRITE = 1'b1; M1_HBURST = 3'b011;
    M1_HWDATA = 32'h7777_0400;
    tick();
    M1_HTRANS = 2'b11; M1_HADDR = 32'h404;
    SI_Reset  = 1'b1;
    tick();
    SI_Reset  = 1'b0;
    M1_HADDR  = 32'h408;
    S_HRESP   = 1'b1;
    settle();
    chk("mrst_owner",  ARB_Owner, 1'b0);
    chk("mrst_htrans", S_HTRANS,  2'b00);
    chk("mrst_m1resp", M1_HRESP,  1'b0);
    chk("mrst_hwdata", S_HWDATA,  32'h0);
    S_HRESP = 1'b0;
    idle_all();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
